// File: rtl/seqdet_pkg.sv
// seqdet_pkg
// Shared types and constants for the parametrised serial pattern detector.
//   state_t        : detector FSM encoding (FILL / ARMED / HIT, 2'd3 unused)
//   SEQDET_DEF_*   : legacy 3-bit default patterns ("001" / "110")
//   seqdet_fill_w  : width of a counter that must hold 0..pat_w
package seqdet_pkg;

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      ARMED = 2'd1,
      HIT   = 2'd2
   } state_t;

   localparam logic [2:0] SEQDET_DEF_PAT_A = 3'b001;
   localparam logic [2:0] SEQDET_DEF_PAT_B = 3'b110;

   function automatic int seqdet_fill_w(input int pat_w);
      return $clog2(pat_w + 1);
   endfunction

endpackage

// File: rtl/seq_detector_param_if.sv
// seq_detector_param_if
// Sample, configuration and result signals of the pattern detector.
//   master : the front end / controller (drives x, x_valid, cfg_*, reads results)
//   slave  : the detector itself
// Handshake: x_valid is a one-way qualifier with no backpressure; x is consumed
// on every rising clk edge where x_valid is high and cfg_load is low. cfg_load
// is a single-cycle command that wins over x_valid in the same cycle.
interface seq_detector_param_if #(
   parameter int PAT_W = 3,
   parameter int CNT_W = 8
);
   logic             x;
   logic             x_valid;
   logic             cfg_load;
   logic [PAT_W-1:0] cfg_pat_a;
   logic [PAT_W-1:0] cfg_pat_b;
   logic             cfg_overlap;
   logic             y_a;
   logic             y_b;
   logic             y;
   logic [1:0]       state;
   logic [CNT_W-1:0] hit_cnt;

   modport master (
      output x, x_valid, cfg_load, cfg_pat_a, cfg_pat_b, cfg_overlap,
      input  y_a, y_b, y, state, hit_cnt
   );

   modport slave (
      input  x, x_valid, cfg_load, cfg_pat_a, cfg_pat_b, cfg_overlap,
      output y_a, y_b, y, state, hit_cnt
   );
endinterface

// File: rtl/seqdet_hist.sv
// seqdet_hist
// History shift register plus saturating fill counter.
//   clk, rst_n  : clock, async active-low reset
//   shift, x    : accept sample x into the LSB of the history
//   clear       : clear history and fill (takes priority over shift)
//   clear_fill  : with shift, restart the fill count (non-overlap match)
//   hist        : current history, oldest sample in the MSB
//   full        : fill has reached PAT_W
//   fill_last   : fill is PAT_W-1, so one more sample fills the window
module seqdet_hist
   import seqdet_pkg::*;
#(
   parameter int PAT_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             shift,
   input  logic             x,
   input  logic             clear,
   input  logic             clear_fill,
   output logic [PAT_W-1:0] hist,
   output logic             full,
   output logic             fill_last
);
   localparam int FW = seqdet_fill_w(PAT_W);
   localparam logic [FW-1:0] FILL_MAX  = FW'(PAT_W);
   localparam logic [FW-1:0] FILL_LAST = FW'(PAT_W - 1);

   logic [PAT_W-1:0] hist_q;
   logic [FW-1:0]    fill_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist_q <= '0;
      end else if (clear) begin
         hist_q <= '0;
      end else if (shift) begin
         hist_q <= {hist_q[PAT_W-2:0], x};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fill_q <= '0;
      end else if (clear) begin
         fill_q <= '0;
      end else if (shift) begin
         if (clear_fill) begin
            fill_q <= '0;
         end else if (fill_q != FILL_MAX) begin
            fill_q <= fill_q + 1'b1;
         end
      end
   end

   assign hist      = hist_q;
   assign full      = (fill_q == FILL_MAX);
   assign fill_last = (fill_q == FILL_LAST);
endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param
// Serial pattern detector with two run-time programmable PAT_W-bit patterns,
// overlapping or non-overlapping detection and registered Moore-style flags.
//   clk, rst_n : clock, async active-low reset
//   bus        : seq_detector_param_if slave modport
//                x/x_valid sample stream, cfg_* reconfiguration (cfg_load),
//                y_a/y_b/y match flags, state (FILL/ARMED/HIT), hit_cnt
// Optional feature macro: SEQDET_CNT_EN -- when defined, a saturating hit
// counter is built; otherwise hit_cnt is tied to zero.
module seq_detector_param
   import seqdet_pkg::*;
#(
   parameter int               PAT_W     = 3,
   parameter int               CNT_W     = 8,
   parameter logic [PAT_W-1:0] DEF_PAT_A = PAT_W'(SEQDET_DEF_PAT_A),
   parameter logic [PAT_W-1:0] DEF_PAT_B = PAT_W'(SEQDET_DEF_PAT_B)
) (
   input  logic               clk,
   input  logic               rst_n,
   seq_detector_param_if.slave bus
);
   logic [PAT_W-1:0] pat_a_q;
   logic [PAT_W-1:0] pat_b_q;
   logic             overlap_q;
   logic [PAT_W-1:0] hist;
   logic [PAT_W-1:0] hist_upd;
   logic             full;
   logic             fill_last;
   logic             accept;
   logic             cand;
   logic             m_a;
   logic             m_b;
   logic             any_match;
   logic             y_a_q;
   logic             y_b_q;
   state_t           state_q;
   state_t           state_d;

   // cfg_load wins: the sample presented in a cfg_load cycle is dropped.
   assign accept = bus.x_valid & ~bus.cfg_load;

   // Matches are judged on the history as it will be after this sample.
   assign hist_upd  = PAT_W'({hist, bus.x});
   assign cand      = full | fill_last;
   assign m_a       = accept & cand & (hist_upd == pat_a_q);
   assign m_b       = accept & cand & (hist_upd == pat_b_q);
   assign any_match = m_a | m_b;

   seqdet_hist #(
      .PAT_W (PAT_W)
   ) u_hist (
      .clk        (clk),
      .rst_n      (rst_n),
      .shift      (accept),
      .x          (bus.x),
      .clear      (bus.cfg_load),
      .clear_fill (any_match & ~overlap_q),
      .hist       (hist),
      .full       (full),
      .fill_last  (fill_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pat_a_q   <= DEF_PAT_A;
         pat_b_q   <= DEF_PAT_B;
         overlap_q <= 1'b1;
      end else if (bus.cfg_load) begin
         pat_a_q   <= bus.cfg_pat_a;
         pat_b_q   <= bus.cfg_pat_b;
         overlap_q <= bus.cfg_overlap;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FILL;
      end else begin
         state_q <= state_d;
      end
   end

   // After a non-overlap match the fill was restarted, so cand is low and a
   // non-matching sample naturally lands in FILL.
   always_comb begin
      state_d = state_q;
      if (bus.cfg_load) begin
         state_d = FILL;
      end else if (accept) begin
         if (any_match) begin
            state_d = HIT;
         end else if (cand) begin
            state_d = ARMED;
         end else begin
            state_d = FILL;
         end
      end else begin
         case (state_q)
            FILL, ARMED, HIT: state_d = state_q;
            default:          state_d = FILL;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_a_q <= 1'b0;
         y_b_q <= 1'b0;
      end else if (bus.cfg_load) begin
         y_a_q <= 1'b0;
         y_b_q <= 1'b0;
      end else if (accept) begin
         y_a_q <= m_a;
         y_b_q <= m_b;
      end
   end

`ifdef SEQDET_CNT_EN
   logic [CNT_W-1:0] hit_cnt_q;

   // One count per matching sample, even when both patterns hit at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_cnt_q <= '0;
      end else if (bus.cfg_load) begin
         hit_cnt_q <= '0;
      end else if (any_match && (hit_cnt_q != {CNT_W{1'b1}})) begin
         hit_cnt_q <= hit_cnt_q + 1'b1;
      end
   end

   assign bus.hit_cnt = hit_cnt_q;
`else
   assign bus.hit_cnt = '0;
`endif

   assign bus.y_a   = y_a_q;
   assign bus.y_b   = y_b_q;
   assign bus.y     = y_a_q | y_b_q;
   assign bus.state = state_q;
endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial pattern detector: watches a 1-bit sample stream and flags matches against two run-time programmable patterns of width PAT_W. Overlapping or non-overlapping detection is selectable. Match flags are registered, Moore-style outputs, and a saturating hit counter is optional. It sits between a serial input front end and the control logic that consumes detection events, and generalises the team's fixed 3-bit "001"/"110" detector.

## Interface
- PAT_W, 3, pattern length in bits (2..16)
- CNT_W, 8, hit counter width
- DEF_PAT_A, 3'b001, pattern A after reset (PAT_W bits, oldest sample in MSB)
- DEF_PAT_B, 3'b110, pattern B after reset
- clk  in  1  rising-edge clock, only clock
- rst_n  in  1  asynchronous, active-low reset
- x  in  1  serial sample
- x_valid  in  1  x is sampled on this edge when high
- cfg_load  in  1  latch cfg_* and clear detection state
- cfg_pat_a  in  PAT_W  new pattern A
- cfg_pat_b  in  PAT_W  new pattern B
- cfg_overlap  in  1  1 = overlapping matches, 0 = non-overlapping
- y_a  out  1  last accepted sample completed pattern A
- y_b  out  1  last accepted sample completed pattern B
- y  out  1  y_a | y_b
- state  out  2  FSM state (FILL/ARMED/HIT)
- hit_cnt  out  CNT_W  saturating match-event count

## Operation
- History register hist[PAT_W-1:0]. On an accepted sample: hist <= {hist[PAT_W-2:0], x}. The newest sample lands in the LSB.
- Fill counter fill (0..PAT_W) counts accepted samples since the last clear. It saturates at PAT_W.
- A sample is a candidate match only when the updated fill equals PAT_W:
  - pattern A matches when updated hist == pat_a
  - pattern B matches when updated hist == pat_b
- FSM states:
  - FILL: fill < PAT_W.
  - ARMED: history is full and the last accepted sample did not match.
  - HIT: the last accepted sample matched A or B.
- Transitions occur only on accepted samples:
  - any state -> HIT on a match
  - otherwise -> ARMED if fill reached PAT_W, else FILL
  - from HIT in non-overlap mode, a non-matching sample goes to FILL, because fill was cleared on the match
- Non-overlap mode (overlap=0): on a match, fill <= 0. The next match therefore needs PAT_W fresh samples. In overlap mode fill is not cleared.
- y_a/y_b are driven from the registered match result. They change only on accepted samples or cfg_load and hold while x_valid=0.
- If both patterns match the same sample (pat_a == pat_b), y_a and y_b both go high and hit_cnt increments by 1.
- cfg_load has priority over x_valid in the same cycle. It latches pat_a, pat_b and overlap, and clears hist, fill, y_a, y_b and hit_cnt. state becomes FILL and the sample in that cycle is discarded.
- Reset: pat_a=DEF_PAT_A, pat_b=DEF_PAT_B, overlap=1, hist=0, fill=0, state=FILL, y_a=y_b=y=0, hit_cnt=0.

## Timing
- Latency: a match on the sample accepted at edge k shows on y_a/y_b/y/state immediately after edge k. The flag stays high until the next accepted sample or cfg_load.
- hit_cnt updates on the same edge as the flags. It saturates at 2^CNT_W-1 and does not wrap.
- rst_n assertion clears all state asynchronously, including mid-pattern. Deassertion is synchronised externally. The first sample is accepted on the first edge with rst_n high.
- The earliest possible match is the PAT_W-th accepted sample after reset or cfg_load.

## Configuration
- SEQDET_CNT_EN
  - Defined: hit_cnt register and increment/saturation logic are present.
  - Undefined: hit_cnt is tied to 0, no counter flops exist, and all other behaviour is unchanged.

## Structure
- Package seqdet_pkg holds:
  - state enum: FILL=2'd0, ARMED=2'd1, HIT=2'd2; 2'd3 unused and recovers to FILL
  - default-pattern constants
  - a function returning the fill-counter width, $clog2(PAT_W+1)
- Sub-module seqdet_hist holds the history shift register and fill counter. Its inputs are shift, clear and clear_fill; its outputs are hist and full. The FSM, match compare, flags and counter stay in the top module.

## Test plan
- Reset with rst_n=0, then release: y=y_a=y_b=0, state=FILL, hit_cnt=0, and no match on the first 2 samples.
- Default patterns, stream x=0,0,1: y_a=1 after the 3rd edge and state=HIT. Next sample x=1: y_a=0, state=ARMED.
- Stream 1,1,0, then x_valid low for 5 cycles: y_b=1 after the 3rd edge and holds through the gap. hit_cnt=1.
- cfg_load with pat_a=101, pat_b=111, overlap=1, then stream 1,0,1,0,1: y_a is high after samples 3 and 5, hit_cnt=2. Repeat with overlap=0: only sample 3 matches, hit_cnt=1.
- CNT_W=2 with SEQDET_CNT_EN defined, 5 matches: hit_cnt ends at 3. Without the macro: hit_cnt stays 0 throughout.
- rst_n pulsed low between samples 2 and 3 of 0,0,1: outputs clear at once, and the following x=1 produces no match (state=FILL).
